// File: rtl/smc_serial_loader.sv
// smc_serial_loader: serial-input transistor-array evaluator.
// Takes six (W, V_GS, V_DS) beats over a valid/ready handshake. Each beat's
// gm or Id value goes into a descending sort buffer by insertion. After the
// sixth beat, a weighted or plain sum of three sorted entries is registered
// onto out_n, with a one-cycle out_valid strobe.
module smc_serial_loader #(
  parameter int unsigned N_TR  = 6,
  parameter int unsigned OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [2:0]       W,
  input  logic [2:0]       V_GS,
  input  logic [2:0]       V_DS,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_n
);

  localparam int unsigned CNT_W  = $clog2(N_TR + 1);
  localparam int unsigned PROD_W = 10;
  localparam int unsigned SUM_W  = OUT_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [1:0]       mode_q;
  logic [OUT_W-1:0] sbuf [N_TR];

  logic             accept_c;
  logic [1:0]       eff_mode_c;
  logic [2:0]       v_c;
  logic             triode_c;
  logic [PROD_W-1:0] w_e_c, d_e_c, v_e_c, num_c;
  logic [OUT_W-1:0] beat_val_c;
  logic [OUT_W-1:0] sbuf_ins_c [N_TR];
  logic [OUT_W-1:0] sel_a_c, sel_b_c, sel_c_c;
  logic [SUM_W-1:0] result_c;

  assign accept_c = in_valid && in_ready;

  // The first beat of a group uses the live mode; later beats use the captured one.
  assign eff_mode_c = (state == ST_IDLE) ? mode : mode_q;

  // Per-beat gm / Id value, with a saturating V_GS-1.
  always_comb begin
    v_c      = (V_GS == 3'd0) ? 3'd0 : (V_GS - 3'd1);
    triode_c = (v_c > V_DS);
    w_e_c    = PROD_W'(W);
    d_e_c    = PROD_W'(V_DS);
    v_e_c    = PROD_W'(v_c);
    num_c    = '0;
    if (!eff_mode_c[0]) begin
      num_c = (w_e_c * (triode_c ? d_e_c : v_e_c)) * PROD_W'(2);
    end else if (triode_c) begin
      num_c = w_e_c * d_e_c * ((v_e_c * PROD_W'(2)) - d_e_c);
    end else begin
      num_c = w_e_c * v_e_c * v_e_c;
    end
    beat_val_c = OUT_W'(num_c / PROD_W'(3));
  end

  // Insertion: the new value lands after every filled entry that is >= it,
  // so ties stay behind existing equal entries and empty slots never compete.
  always_comb begin
    logic             prev_ge;
    logic             ge;
    logic [OUT_W-1:0] prev_val;
    prev_ge  = 1'b1;
    prev_val = '0;
    for (int i = 0; i < int'(N_TR); i++) begin
      ge = (CNT_W'(i) < count) && (sbuf[i] >= beat_val_c);
      if (ge) begin
        sbuf_ins_c[i] = sbuf[i];
      end else if (prev_ge) begin
        sbuf_ins_c[i] = beat_val_c;
      end else begin
        sbuf_ins_c[i] = prev_val;
      end
      prev_ge  = ge;
      prev_val = sbuf[i];
    end
  end

  // Pick the top or bottom three entries and form the mode-selected sum.
  always_comb begin
    if (mode_q[1]) begin
      sel_a_c = sbuf[0];
      sel_b_c = sbuf[1];
      sel_c_c = sbuf[2];
    end else begin
      sel_a_c = sbuf[N_TR-3];
      sel_b_c = sbuf[N_TR-2];
      sel_c_c = sbuf[N_TR-1];
    end
    if (mode_q[0]) begin
      result_c = (SUM_W'(3) * SUM_W'(sel_a_c)) + (SUM_W'(4) * SUM_W'(sel_b_c)) +
                 (SUM_W'(5) * SUM_W'(sel_c_c));
    end else begin
      result_c = SUM_W'(sel_a_c) + SUM_W'(sel_b_c) + SUM_W'(sel_c_c);
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      mode_q    <= 2'b00;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_n     <= '0;
      for (int i = 0; i < int'(N_TR); i++) sbuf[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            mode_q <= mode;
            count  <= CNT_W'(1);
            for (int i = 0; i < int'(N_TR); i++) sbuf[i] <= sbuf_ins_c[i];
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept_c) begin
            count <= count + CNT_W'(1);
            for (int i = 0; i < int'(N_TR); i++) sbuf[i] <= sbuf_ins_c[i];
            if (count == CNT_W'(N_TR - 1)) begin
              in_ready <= 1'b0;
              state    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          out_n     <= OUT_W'(result_c);
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          out_valid <= 1'b0;
          count     <= '0;
          for (int i = 0; i < int'(N_TR); i++) sbuf[i] <= '0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smc_serial_loader.sv
// tb_smc_serial_loader: directed bench for smc_serial_loader.
module tb_smc_serial_loader;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode;
  logic [2:0] W;
  logic [2:0] V_GS;
  logic [2:0] V_DS;
  logic       out_valid;
  logic [9:0] out_n;

  int n_pass;
  int n_total;

  logic [2:0] bw [6];
  logic [2:0] bg [6];
  logic [2:0] bd [6];

  smc_serial_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .W         (W),
    .V_GS      (V_GS),
    .V_DS      (V_DS),
    .out_valid (out_valid),
    .out_n     (out_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic set_uniform(input logic [2:0] w, input logic [2:0] g, input logic [2:0] d);
    for (int i = 0; i < 6; i++) begin
      bw[i] = w; bg[i] = g; bd[i] = d;
    end
  endtask

  // W presented as 5,2,6,1,4,3 with V_GS=3, V_DS=3.
  task automatic set_worder();
    bw[0] = 3'd5; bw[1] = 3'd2; bw[2] = 3'd6;
    bw[3] = 3'd1; bw[4] = 3'd4; bw[5] = 3'd3;
    for (int i = 0; i < 6; i++) begin
      bg[i] = 3'd3; bd[i] = 3'd3;
    end
  endtask

  // Drive one six-beat group, then check CALC / OUT / return-to-idle timing.
  task automatic run_group(input string tag, input logic [1:0] m, input logic [1:0] m_late,
                           input int gaps, input logic [9:0] exp, input bit hold,
                           input logic [1:0] hm, input logic [2:0] hw,
                           input logic [2:0] hg, input logic [2:0] hd);
    int g;
    for (int b = 0; b < 6; b++) begin
      g = (gaps > 0) ? int'($urandom_range(gaps, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (b == 0) chk({tag, "_ready_first"}, int'(in_ready), 1);
      in_valid = 1'b1;
      mode     = (b < 3) ? m : m_late;
      W        = bw[b];
      V_GS     = bg[b];
      V_DS     = bd[b];
      @(posedge clk); #1;
    end
    if (hold) begin
      in_valid = 1'b1; mode = hm; W = hw; V_GS = hg; V_DS = hd;
    end else begin
      in_valid = 1'b0;
    end
    chk({tag, "_calc_valid"}, int'(out_valid), 0);
    chk({tag, "_calc_ready"}, int'(in_ready), 0);
    @(posedge clk); #1;
    chk({tag, "_out_valid"}, int'(out_valid), 1);
    chk({tag, "_out_n"}, int'(out_n), int'(exp));
    chk({tag, "_out_ready"}, int'(in_ready), 0);
    @(posedge clk); #1;
    chk({tag, "_post_valid"}, int'(out_valid), 0);
    chk({tag, "_post_hold"}, int'(out_n), int'(exp));
    chk({tag, "_post_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    bit seen_valid;
    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    mode     = 2'b00;
    W        = 3'd0;
    V_GS     = 3'd0;
    V_DS     = 3'd0;

    @(posedge clk); #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_n", int'(out_n), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Saturation, gm: each value 4, bottom three sum to 12.
    set_uniform(3'd3, 3'd3, 3'd3);
    run_group("sat_gm", 2'b00, 2'b00, 0, 10'd12, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0);

    // Values {1,2,4,5,6,8} inserted out of order, all four modes.
    set_worder();
    run_group("ord_10", 2'b10, 2'b10, 0, 10'd19, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0);
    run_group("ord_00", 2'b00, 2'b00, 0, 10'd7,  1'b0, 2'b00, 3'd0, 3'd0, 3'd0);
    run_group("ord_11", 2'b11, 2'b11, 0, 10'd73, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0);
    run_group("ord_01", 2'b01, 2'b01, 0, 10'd25, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0);

    // Triode: W=6,V_GS=7,V_DS=2 -> Id 40 / gm 8; W=0 beats give 0.
    set_uniform(3'd0, 3'd7, 3'd2);
    bw[0] = 3'd6;
    run_group("tri_id", 2'b11, 2'b11, 0, 10'd120, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0);
    run_group("tri_gm", 2'b10, 2'b10, 0, 10'd8,   1'b0, 2'b00, 3'd0, 3'd0, 3'd0);

    // Maximum: Id 84 each -> 12*84.
    set_uniform(3'd7, 3'd7, 3'd7);
    run_group("max_id", 2'b11, 2'b11, 0, 10'd1008, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0);

    // V_GS=0 saturates v to 0 -> every value 0.
    set_uniform(3'd7, 3'd0, 3'd3);
    run_group("vgs0", 2'b11, 2'b11, 0, 10'd0, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0);

    // Random gaps between beats give the gap-free results.
    set_worder();
    run_group("gap_11", 2'b11, 2'b11, 3, 10'd73, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0);
    run_group("gap_01", 2'b01, 2'b01, 3, 10'd25, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0);

    // Mode flipped from beat 3 onward is ignored.
    run_group("modechg", 2'b11, 2'b00, 0, 10'd73, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0);

    // in_valid held through CALC/OUT with the next group's first beat;
    // that beat must be taken only at the first edge after OUT.
    run_group("hold_a", 2'b10, 2'b10, 0, 10'd19, 1'b1, 2'b00, 3'd3, 3'd3, 3'd3);
    set_uniform(3'd3, 3'd3, 3'd3);
    run_group("hold_b", 2'b00, 2'b00, 0, 10'd12, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0);

    // Reset after four beats discards the partial group.
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1; mode = 2'b00; W = bw[b]; V_GS = bg[b]; V_DS = bd[b];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_n", int'(out_n), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    chk("midrst_no_strobe", int'(seen_valid), 0);
    chk("midrst_idle_ready", int'(in_ready), 1);
    run_group("after_rst", 2'b00, 2'b00, 0, 10'd12, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
